alu_share_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational `alu` instance among `NREQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block latches the winning request and drives the ALU from registers for one cycle. It then captures the result and the four flags, and returns them on a single tagged response channel with backpressure. It sits between the issue/sequencer logic and the shared ALU.

---
 rtl/alu_share_arbiter_if.sv | 46 ++++
 rtl/alu_share_arbiter.sv | 84 ++++++++
 tb/tb_alu_share_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, shared-ALU and tagged response signals of the arbiter
interface alu_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [4*NREQ-1:0]  req_aluc;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [3:0]         alu_aluc;
    logic [31:0]        alu_r;
    logic               alu_zero;
    logic               alu_carry;
    logic               alu_negative;
    logic               alu_overflow;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_r;
    logic               resp_zero;
    logic               resp_carry;
    logic               resp_negative;
    logic               resp_overflow;
    logic               busy;

    modport slave (
        input  req_valid, req_a, req_b, req_aluc,
        input  alu_r, alu_zero, alu_carry, alu_negative, alu_overflow,
        input  resp_ready,
        output req_ready, alu_a, alu_b, alu_aluc,
        output resp_valid, resp_id, resp_r, resp_zero, resp_carry, resp_negative, resp_overflow,
        output busy
    );

    modport master (
        output req_valid, req_a, req_b, req_aluc,
        output alu_r, alu_zero, alu_carry, alu_negative, alu_overflow,
        output resp_ready,
        input  req_ready, alu_a, alu_b, alu_aluc,
        input  resp_valid, resp_id, resp_r, resp_zero, resp_carry, resp_negative, resp_overflow,
        input  busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU among NREQ requesters
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant;
    logic           found;

    // first valid requester at or after ptr, wrapping around
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                grant = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // next state and accept strobe; ready is gated by rst_n so reset always masks it
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: if (found) begin
                state_nxt            = EXEC;
                bus.req_ready[grant] = rst_n;
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = bus.resp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.resp_valid = state == RESP;
    assign bus.busy       = state != IDLE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // operand latch on accept, result capture in EXEC, pointer advance on response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr               <= '0;
            bus.alu_a         <= '0;
            bus.alu_b         <= '0;
            bus.alu_aluc      <= '0;
            bus.resp_id       <= '0;
            bus.resp_r        <= '0;
            bus.resp_zero     <= 1'b0;
            bus.resp_carry    <= 1'b0;
            bus.resp_negative <= 1'b0;
            bus.resp_overflow <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                bus.alu_a    <= bus.req_a[32*grant +: 32];
                bus.alu_b    <= bus.req_b[32*grant +: 32];
                bus.alu_aluc <= bus.req_aluc[4*grant +: 4];
                bus.resp_id  <= grant;
            end
            if (state == EXEC) begin
                bus.resp_r        <= bus.alu_r;
                bus.resp_zero     <= bus.alu_zero;
                bus.resp_carry    <= bus.alu_carry;
                bus.resp_negative <= bus.alu_negative;
                bus.resp_overflow <= bus.alu_overflow;
            end
            if (state == RESP && bus.resp_ready)
                ptr <= (bus.resp_id == IDW'(NREQ - 1)) ? '0 : bus.resp_id + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for the shared-ALU round-robin arbiter
module tb_alu_share_arbiter;
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] r;
        logic [3:0]  f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_g = 0;
    int          cnt [4];
    int          gq [$];
    exp_t        sb [$];
    exp_t        e;
    logic [3:0]  acc = '0;
    logic        fair_on = 1'b0;
    logic        fair_have = 1'b0;
    logic        prev_rv = 1'b0;
    logic        g;
    logic [32:0] s;

    alu_share_arbiter_if #(.NREQ(4), .IDW(2)) bus ();
    alu_share_arbiter #(.NREQ(4), .IDW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) acc <= bus.req_ready;

    // reference ALU: 0000 and, 0001 or, 0010 add, 0011 sub, others xor
    always_comb begin
        s                = '0;
        bus.alu_carry    = 1'b0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_aluc)
            4'b0010: begin
                s                = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_carry    = s[32];
                bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (s[31] != bus.alu_a[31]);
            end
            4'b0011: begin
                s                = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
                bus.alu_carry    = s[32];
                bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (s[31] != bus.alu_a[31]);
            end
            4'b0000: s = {1'b0, bus.alu_a & bus.alu_b};
            4'b0001: s = {1'b0, bus.alu_a | bus.alu_b};
            default: s = {1'b0, bus.alu_a ^ bus.alu_b};
        endcase
        bus.alu_r        = s[31:0];
        bus.alu_zero     = s[31:0] == 32'd0;
        bus.alu_negative = s[31];
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: grants and responses are popped from the scoreboard queues as they appear
    always @(negedge clk) begin
        if (!rst_n) prev_rv = 1'b0;
        else begin
            if (bus.req_ready != 4'd0) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant: unexpected req_ready %b", bus.req_ready);
                end else chk("grant", 32'(bus.req_ready), 32'(1) << gq.pop_front());
                if (fair_on && fair_have) chk("grant_spacing", cyc - last_g, 3);
                fair_have = fair_on;
                last_g    = cyc;
            end
            if (bus.resp_valid && !prev_rv) chk("latency", cyc - last_g, 2);
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp: unexpected response id %0d r %h", bus.resp_id, bus.resp_r);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                    chk("resp_r", bus.resp_r, e.r);
                    chk("resp_flags", 32'({bus.resp_zero, bus.resp_carry, bus.resp_negative, bus.resp_overflow}), 32'(e.f));
                end
            end
            prev_rv = bus.resp_valid;
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (acc[i] && cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) bus.req_valid[i] = 1'b0;
            end
    endtask

    task automatic req(int i, logic [31:0] a, logic [31:0] b, logic [3:0] c, int n);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_aluc[4*i +: 4] = c;
        cnt[i] = n;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic expect_op(int id, logic [31:0] r, logic [3:0] f);
        gq.push_back(id);
        sb.push_back({2'(id), r, f});
    endtask

    task automatic run(string nm);
        for (int n = 0; n <= 300; n++) begin
            @(negedge clk);
            if (bus.req_valid == 4'd0 && gq.size() == 0 && sb.size() == 0 && !bus.busy) break;
            if (n == 300) begin
                checks++;
                errors++;
                $display("FAIL %s: timeout with %0d responses outstanding", nm, sb.size());
                break;
            end
            adv();
        end
        adv();
    endtask

    task automatic chk_reset_values(string nm);
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({nm, "_alu_a"}, bus.alu_a, 32'd0);
        chk({nm, "_alu_b"}, bus.alu_b, 32'd0);
        chk({nm, "_alu_aluc"}, 32'(bus.alu_aluc), 32'd0);
        chk({nm, "_resp_id"}, 32'(bus.resp_id), 32'd0);
        chk({nm, "_resp_r"}, bus.resp_r, 32'd0);
        chk({nm, "_resp_flags"}, 32'({bus.resp_zero, bus.resp_carry, bus.resp_negative, bus.resp_overflow}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        bus.req_valid  = '1;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_aluc   = '0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk_reset_values("por");
        bus.req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        req(1, 32'd5, 32'd3, 4'b0011, 1);
        expect_op(1, 32'd2, 4'b0000);
        run("single");

        req(0, 32'h7FFFFFFF, 32'd1, 4'b0010, 1);
        expect_op(0, 32'h80000000, 4'b0011);
        run("overflow");

        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        fair_on = 1'b1;
        for (int i = 0; i < 4; i++) req(i, 32'(i + 10), 32'(i), 4'b0010, i == 0 ? 2 : 1);
        for (int i = 0; i < 4; i++) expect_op(i, 32'(2 * i + 10), 4'b0000);
        expect_op(0, 32'd10, 4'b0000);
        run("fairness");
        fair_on = 1'b0;

        bus.resp_ready = 1'b0;
        req(3, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0000, 1);
        expect_op(3, 32'h00F000F0, 4'b0000);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.resp_valid) break;
            adv();
        end
        adv();
        req(2, 32'd1, 32'd1, 4'b0011, 1);
        expect_op(2, 32'd0, 4'b1000);
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_resp_id", 32'(bus.resp_id), 32'd3);
            chk("bp_resp_r", bus.resp_r, 32'h00F000F0);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
            adv();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        adv();
        @(negedge clk);
        chk("bp_idle_busy", 32'(bus.busy), 32'd0);
        chk("bp_next_ready", 32'(bus.req_ready), 32'b0100);
        adv();
        run("backpressure");

        req(0, 32'h12345678, 32'h12345678, 4'b0100, 1);
        req(2, 32'd0, 32'd1, 4'b0011, 1);
        expect_op(0, 32'd0, 4'b1000);
        expect_op(2, 32'hFFFFFFFF, 4'b0110);
        run("pointer");

        req(1, 32'd7, 32'd8, 4'b0010, 1);
        gq.push_back(1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            g = bus.req_ready[1];
            adv();
            if (g) break;
        end
        chk("exec_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_values("mid_rst");
        @(negedge clk);
        chk("mid_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req(1, 32'd7, 32'd8, 4'b0010, 1);
        req(3, 32'd2, 32'd3, 4'b0001, 1);
        expect_op(1, 32'd15, 4'b0000);
        expect_op(3, 32'd3, 4'b0000);
        run("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
